// File: rtl/rvx_core_branch_predictor_if.sv
// rvx_core_branch_predictor_if
//   Groups the fetch-stage prediction port, the s1 resolve port and the
//   statistics outputs of the branch predictor into one bundle.
//   master : drives pc_s0 and the s1 instruction fields, observes results.
//   slave  : the predictor itself.
interface rvx_core_branch_predictor_if #(
    parameter int XLEN       = 32,
    parameter int STAT_WIDTH = 32
) ();
    // s0 (fetch) prediction
    logic [XLEN-1:0]       pc_s0;
    logic                  predict_taken_s0;
    // s1 resolve
    logic                  valid_s1;
    logic [XLEN-1:0]       pc_s1;
    logic                  branch_s1;
    logic                  jump_s1;
    logic [2:0]            funct3_s1;
    logic [XLEN-1:0]       rs1_data_s1;
    logic [XLEN-1:0]       rs2_data_s1;
    logic                  predicted_taken_s1;
    logic                  take_branch_s1;
    logic                  mispredict_s1;
    // statistics for the CSR block
    logic [STAT_WIDTH-1:0] branch_count;
    logic [STAT_WIDTH-1:0] mispredict_count;

    modport master (
        output pc_s0, valid_s1, pc_s1, branch_s1, jump_s1, funct3_s1,
               rs1_data_s1, rs2_data_s1, predicted_taken_s1,
        input  predict_taken_s0, take_branch_s1, mispredict_s1,
               branch_count, mispredict_count
    );

    modport slave (
        input  pc_s0, valid_s1, pc_s1, branch_s1, jump_s1, funct3_s1,
               rs1_data_s1, rs2_data_s1, predicted_taken_s1,
        output predict_taken_s0, take_branch_s1, mispredict_s1,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/rvx_core_branch_predictor.sv
// rvx_core_branch_predictor
//   XLEN-wide branch resolver plus a BHT of 2-bit saturating counters.
//   s0: combinational taken/not-taken prediction for pc_s0.
//   s1: combinational branch/jump resolution and mispredict flag; on the
//       clock edge the BHT entry of pc_s1 is trained and the saturating
//       branch / mispredict statistics counters are advanced.
// Ports:
//   clock  - core clock, rising edge
//   reset  - asynchronous, active-high
//   bus    - slave side of rvx_core_branch_predictor_if
module rvx_core_branch_predictor #(
    parameter int         XLEN           = 32,
    parameter int         BHT_DEPTH      = 64,
    parameter logic [1:0] COUNTER_INIT   = 2'b01,
    parameter bit         PREDICT_ENABLE = 1'b1,
    parameter int         STAT_WIDTH     = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    rvx_core_branch_predictor_if.slave    bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] idx_s0;
    logic [IDX_W-1:0] idx_s1;
    logic             eq;
    logic             ltu;
    logic             lt;
    logic             cond;
    logic             resolve;
    logic             train;
    logic             mispredict;

    // Index drops the halfword/byte bits; upper PC bits alias onto the table.
    assign idx_s0 = bus.pc_s0[IDX_W+1:2];
    assign idx_s1 = bus.pc_s1[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.pc_s0[XLEN-1:IDX_W+2], bus.pc_s0[1:0],
                              bus.pc_s1[XLEN-1:IDX_W+2], bus.pc_s1[1:0]};

    // No bypass: a same-cycle write to idx_s0 is seen only next cycle.
    assign bus.predict_taken_s0 = PREDICT_ENABLE & bht[idx_s0][1];

    // Signed compare reuses the unsigned one: when the sign bits differ the
    // negative operand (MSB set) is the smaller one.
    assign eq  = (bus.rs1_data_s1 == bus.rs2_data_s1);
    assign ltu = (bus.rs1_data_s1 <  bus.rs2_data_s1);
    assign lt  = (bus.rs1_data_s1[XLEN-1] != bus.rs2_data_s1[XLEN-1])
               ? bus.rs1_data_s1[XLEN-1] : ltu;

    always_comb begin
        cond = 1'b0;
        case (bus.funct3_s1)
            3'b000:  cond = eq;
            3'b001:  cond = ~eq;
            3'b100:  cond = lt;
            3'b101:  cond = ~lt;
            3'b110:  cond = ltu;
            3'b111:  cond = ~ltu;
            default: cond = 1'b0;
        endcase
    end

    // A jump overrides a simultaneously flagged branch and never mispredicts.
    assign resolve    = bus.valid_s1 & bus.branch_s1 & ~bus.jump_s1;
    assign train      = resolve & PREDICT_ENABLE;
    assign mispredict = resolve & (cond != bus.predicted_taken_s1);

    assign bus.take_branch_s1 = bus.jump_s1 | (bus.branch_s1 & cond);
    assign bus.mispredict_s1  = mispredict;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= COUNTER_INIT;
        end else if (train) begin
            if (cond) begin
                if (bht[idx_s1] != 2'b11) bht[idx_s1] <= bht[idx_s1] + 2'd1;
            end else begin
                if (bht[idx_s1] != 2'b00) bht[idx_s1] <= bht[idx_s1] - 2'd1;
            end
        end
    end

    // Statistics stick at all-ones instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.branch_count     <= '0;
            bus.mispredict_count <= '0;
        end else if (resolve) begin
            if (bus.branch_count != '1)
                bus.branch_count <= bus.branch_count + 1'b1;
            if (mispredict && (bus.mispredict_count != '1))
                bus.mispredict_count <= bus.mispredict_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_rvx_core_branch_predictor.sv
// tb_rvx_core_branch_predictor
//   Directed bench for rvx_core_branch_predictor. Three instances share one
//   stimulus: the default configuration, a STAT_WIDTH = 4 copy for counter
//   saturation, and a PREDICT_ENABLE = 0 copy for static prediction.
module tb_rvx_core_branch_predictor;
    logic clock;
    logic reset;
    int   vecs;
    int   errs;

    rvx_core_branch_predictor_if #(.XLEN(32), .STAT_WIDTH(32)) bi ();
    rvx_core_branch_predictor_if #(.XLEN(32), .STAT_WIDTH(4))  bs ();
    rvx_core_branch_predictor_if #(.XLEN(32), .STAT_WIDTH(32)) bp ();

    assign bs.pc_s0 = bi.pc_s0;               assign bp.pc_s0 = bi.pc_s0;
    assign bs.valid_s1 = bi.valid_s1;         assign bp.valid_s1 = bi.valid_s1;
    assign bs.pc_s1 = bi.pc_s1;               assign bp.pc_s1 = bi.pc_s1;
    assign bs.branch_s1 = bi.branch_s1;       assign bp.branch_s1 = bi.branch_s1;
    assign bs.jump_s1 = bi.jump_s1;           assign bp.jump_s1 = bi.jump_s1;
    assign bs.funct3_s1 = bi.funct3_s1;       assign bp.funct3_s1 = bi.funct3_s1;
    assign bs.rs1_data_s1 = bi.rs1_data_s1;   assign bp.rs1_data_s1 = bi.rs1_data_s1;
    assign bs.rs2_data_s1 = bi.rs2_data_s1;   assign bp.rs2_data_s1 = bi.rs2_data_s1;
    assign bs.predicted_taken_s1 = bi.predicted_taken_s1;
    assign bp.predicted_taken_s1 = bi.predicted_taken_s1;

    rvx_core_branch_predictor #(.XLEN(32), .BHT_DEPTH(64), .COUNTER_INIT(2'b01),
        .PREDICT_ENABLE(1'b1), .STAT_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .bus(bi.slave));

    rvx_core_branch_predictor #(.XLEN(32), .BHT_DEPTH(64), .COUNTER_INIT(2'b01),
        .PREDICT_ENABLE(1'b1), .STAT_WIDTH(4)) dut_small (
        .clock(clock), .reset(reset), .bus(bs.slave));

    rvx_core_branch_predictor #(.XLEN(32), .BHT_DEPTH(64), .COUNTER_INIT(2'b01),
        .PREDICT_ENABLE(1'b0), .STAT_WIDTH(32)) dut_static (
        .clock(clock), .reset(reset), .bus(bp.slave));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Pulse reset away from the rising edge; inputs left idle.
    task automatic do_reset;
        @(negedge clock);
        bi.valid_s1 = 1'b0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] pcs [3];
        pcs = '{32'h0, 32'h4, 32'hFC};
        reset = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            bi.pc_s0 = pcs[i];
            #1;
            vecs++;
            if (bi.predict_taken_s0 !== 1'b0) begin
                errs++;
                $display("FAIL reset_predict pc=%h got %b want 0", pcs[i], bi.predict_taken_s0);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        vecs++;
        if (bi.branch_count !== 32'd0 || bi.mispredict_count !== 32'd0) begin
            errs++;
            $display("FAIL reset_counts got %0d/%0d want 0/0", bi.branch_count, bi.mispredict_count);
        end
    endtask

    task automatic test_compare;
        logic [31:0] t_rs1 [12];
        logic [31:0] t_rs2 [12];
        logic [2:0]  t_f3  [12];
        logic        t_exp [12];
        t_rs1 = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                  32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                  32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd5, 32'd1};
        t_rs2 = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
        t_f3  = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b010, 3'b011, 3'b000, 3'b001,
                  3'b100, 3'b111, 3'b000, 3'b100};
        t_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b1, 1'b0, 1'b1, 1'b0};
        bi.valid_s1 = 1'b0;
        bi.branch_s1 = 1'b1;
        bi.jump_s1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bi.rs1_data_s1 = t_rs1[i];
            bi.rs2_data_s1 = t_rs2[i];
            bi.funct3_s1 = t_f3[i];
            #1;
            vecs++;
            if (bi.take_branch_s1 !== t_exp[i]) begin
                errs++;
                $display("FAIL cmp_take row=%0d f3=%b got %b want %b", i, t_f3[i], bi.take_branch_s1, t_exp[i]);
            end
        end
        // Live-instruction checks stay inside one low phase so no edge trains.
        @(negedge clock);
        bi.rs1_data_s1 = 32'h8000_0000;
        bi.rs2_data_s1 = 32'd1;
        bi.funct3_s1 = 3'b100;
        bi.predicted_taken_s1 = 1'b0;
        bi.valid_s1 = 1'b1;
        #1;
        vecs++;
        if (bi.mispredict_s1 !== 1'b1) begin
            errs++;
            $display("FAIL cmp_mispredict got %b want 1", bi.mispredict_s1);
        end
        bi.predicted_taken_s1 = 1'b1;
        #1;
        vecs++;
        if (bi.mispredict_s1 !== 1'b0) begin
            errs++;
            $display("FAIL cmp_correct got %b want 0", bi.mispredict_s1);
        end
        bi.jump_s1 = 1'b1;
        bi.funct3_s1 = 3'b010;
        bi.predicted_taken_s1 = 1'b0;
        #1;
        vecs++;
        if (bi.take_branch_s1 !== 1'b1 || bi.mispredict_s1 !== 1'b0) begin
            errs++;
            $display("FAIL cmp_jump take=%b misp=%b want 1/0", bi.take_branch_s1, bi.mispredict_s1);
        end
        bi.valid_s1 = 1'b0;
        bi.jump_s1 = 1'b0;
        @(negedge clock);
        vecs++;
        if (bi.branch_count !== 32'd0) begin
            errs++;
            $display("FAIL cmp_no_count got %0d want 0", bi.branch_count);
        end
    endtask

    task automatic test_training;
        do_reset();
        bi.pc_s0 = 32'h40;
        bi.pc_s1 = 32'h40;
        bi.branch_s1 = 1'b1;
        bi.jump_s1 = 1'b0;
        bi.funct3_s1 = 3'b000;
        bi.rs1_data_s1 = 32'd5;
        bi.rs2_data_s1 = 32'd5;
        bi.predicted_taken_s1 = 1'b0;
        bi.valid_s1 = 1'b1;
        #1;
        vecs++;
        if (bi.mispredict_s1 !== 1'b1 || bi.predict_taken_s0 !== 1'b0) begin
            errs++;
            $display("FAIL train_c0 misp=%b pred=%b want 1/0", bi.mispredict_s1, bi.predict_taken_s0);
        end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clock);
            bi.predicted_taken_s1 = 1'b1;
            #1;
            vecs++;
            if (bi.mispredict_s1 !== 1'b0 || bi.predict_taken_s0 !== 1'b1) begin
                errs++;
                $display("FAIL train_c%0d misp=%b pred=%b want 0/1", c, bi.mispredict_s1, bi.predict_taken_s0);
            end
        end
        @(negedge clock);
        bi.valid_s1 = 1'b0;
        #1;
        vecs++;
        if (bi.branch_count !== 32'd3 || bi.mispredict_count !== 32'd1) begin
            errs++;
            $display("FAIL train_counts got %0d/%0d want 3/1", bi.branch_count, bi.mispredict_count);
        end
        vecs++;
        if (bp.predict_taken_s0 !== 1'b0) begin
            errs++;
            $display("FAIL static_predict got %b want 0", bp.predict_taken_s0);
        end
        // Counter sits at 11: one not-taken keeps bit1, the second clears it.
        bi.rs2_data_s1 = 32'd6;
        bi.valid_s1 = 1'b1;
        @(negedge clock);
        #1;
        vecs++;
        if (bi.predict_taken_s0 !== 1'b1) begin
            errs++;
            $display("FAIL train_sat_hi got %b want 1", bi.predict_taken_s0);
        end
        @(negedge clock);
        bi.valid_s1 = 1'b0;
        #1;
        vecs++;
        if (bi.predict_taken_s0 !== 1'b0) begin
            errs++;
            $display("FAIL train_down got %b want 0", bi.predict_taken_s0);
        end
        vecs++;
        if (bi.branch_count !== 32'd5 || bi.mispredict_count !== 32'd3) begin
            errs++;
            $display("FAIL train_counts2 got %0d/%0d want 5/3", bi.branch_count, bi.mispredict_count);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        bi.pc_s0 = 32'h80;
        bi.pc_s1 = 32'h80;
        bi.branch_s1 = 1'b1;
        bi.funct3_s1 = 3'b000;
        bi.rs1_data_s1 = 32'd1;
        bi.rs2_data_s1 = 32'd2;
        bi.predicted_taken_s1 = 1'b0;
        bi.valid_s1 = 1'b1;
        @(negedge clock);           // 01 -> 00
        bi.rs2_data_s1 = 32'd1;
        @(negedge clock);           // 00 -> 01
        #1;
        vecs++;
        if (bi.predict_taken_s0 !== 1'b0) begin
            errs++;
            $display("FAIL b2b_mid got %b want 0", bi.predict_taken_s0);
        end
        @(negedge clock);           // 01 -> 10
        bi.valid_s1 = 1'b0;
        #1;
        vecs++;
        if (bi.predict_taken_s0 !== 1'b1) begin
            errs++;
            $display("FAIL b2b_end got %b want 1", bi.predict_taken_s0);
        end
    endtask

    task automatic test_alias;
        do_reset();
        bi.pc_s0 = 32'h0;
        bi.pc_s1 = 32'h100;
        bi.branch_s1 = 1'b1;
        bi.funct3_s1 = 3'b000;
        bi.rs1_data_s1 = 32'd9;
        bi.rs2_data_s1 = 32'd9;
        bi.predicted_taken_s1 = 1'b0;
        bi.valid_s1 = 1'b1;
        #1;
        vecs++;
        if (bi.predict_taken_s0 !== 1'b0) begin
            errs++;
            $display("FAIL alias_same_cycle got %b want 0", bi.predict_taken_s0);
        end
        @(negedge clock);
        bi.valid_s1 = 1'b0;
        #1;
        vecs++;
        if (bi.predict_taken_s0 !== 1'b1) begin
            errs++;
            $display("FAIL alias_next got %b want 1", bi.predict_taken_s0);
        end
        bi.pc_s0 = 32'h200;
        #1;
        vecs++;
        if (bi.predict_taken_s0 !== 1'b1) begin
            errs++;
            $display("FAIL alias_200 got %b want 1", bi.predict_taken_s0);
        end
        bi.pc_s0 = 32'h4;
        #1;
        vecs++;
        if (bi.predict_taken_s0 !== 1'b0) begin
            errs++;
            $display("FAIL alias_other got %b want 0", bi.predict_taken_s0);
        end
    endtask

    // Runs after test_alias: idx 0 holds 10, counters at 1/1.
    task automatic test_stall;
        bi.pc_s0 = 32'h0;
        bi.pc_s1 = 32'h100;
        bi.branch_s1 = 1'b1;
        bi.funct3_s1 = 3'b000;
        bi.predicted_taken_s1 = 1'b1;
        bi.valid_s1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            bi.rs1_data_s1 = 32'(i);
            bi.rs2_data_s1 = 32'(i);
            #1;
            vecs++;
            if (bi.take_branch_s1 !== 1'b1) begin
                errs++;
                $display("FAIL stall_take_eq cyc=%0d got %b want 1", i, bi.take_branch_s1);
            end
            bi.rs2_data_s1 = 32'(i + 1);
            #1;
            vecs++;
            if (bi.take_branch_s1 !== 1'b0) begin
                errs++;
                $display("FAIL stall_take_ne cyc=%0d got %b want 0", i, bi.take_branch_s1);
            end
        end
        @(negedge clock);
        #1;
        vecs++;
        if (bi.predict_taken_s0 !== 1'b1) begin
            errs++;
            $display("FAIL stall_bht got %b want 1", bi.predict_taken_s0);
        end
        vecs++;
        if (bi.branch_count !== 32'd1 || bi.mispredict_count !== 32'd1) begin
            errs++;
            $display("FAIL stall_counts got %0d/%0d want 1/1", bi.branch_count, bi.mispredict_count);
        end
    endtask

    task automatic test_saturation;
        do_reset();
        bi.pc_s0 = 32'h40;
        bi.pc_s1 = 32'h40;
        bi.branch_s1 = 1'b1;
        bi.funct3_s1 = 3'b000;
        bi.rs1_data_s1 = 32'd7;
        bi.rs2_data_s1 = 32'd7;
        bi.predicted_taken_s1 = 1'b0;
        bi.valid_s1 = 1'b1;
        repeat (20) @(negedge clock);
        bi.valid_s1 = 1'b0;
        #1;
        vecs++;
        if (bs.branch_count !== 4'd15 || bs.mispredict_count !== 4'd15) begin
            errs++;
            $display("FAIL sat_small got %0d/%0d want 15/15", bs.branch_count, bs.mispredict_count);
        end
        vecs++;
        if (bi.branch_count !== 32'd20 || bi.mispredict_count !== 32'd20) begin
            errs++;
            $display("FAIL sat_wide got %0d/%0d want 20/20", bi.branch_count, bi.mispredict_count);
        end
        vecs++;
        if (bp.branch_count !== 32'd20 || bp.mispredict_count !== 32'd20) begin
            errs++;
            $display("FAIL sat_static got %0d/%0d want 20/20", bp.branch_count, bp.mispredict_count);
        end
        vecs++;
        if (bi.predict_taken_s0 !== 1'b1) begin
            errs++;
            $display("FAIL sat_bht got %b want 1", bi.predict_taken_s0);
        end
    endtask

    // Idx 16 is at 11 and counters are non-zero from test_saturation.
    task automatic test_async_reset;
        bi.valid_s1 = 1'b1;         // pending taken update to idx 16
        #1;
        reset = 1'b1;
        #1;
        vecs++;
        if (bi.branch_count !== 32'd0 || bi.mispredict_count !== 32'd0 ||
            bs.branch_count !== 4'd0) begin
            errs++;
            $display("FAIL async_counts got %0d/%0d/%0d want 0/0/0",
                     bi.branch_count, bi.mispredict_count, bs.branch_count);
        end
        vecs++;
        if (bi.predict_taken_s0 !== 1'b0) begin
            errs++;
            $display("FAIL async_bht got %b want 0", bi.predict_taken_s0);
        end
        @(negedge clock);
        bi.valid_s1 = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        vecs++;
        if (bi.predict_taken_s0 !== 1'b0 || bi.branch_count !== 32'd0) begin
            errs++;
            $display("FAIL async_discard pred=%b cnt=%0d want 0/0", bi.predict_taken_s0, bi.branch_count);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        reset = 1'b1;
        bi.pc_s0 = '0;
        bi.valid_s1 = 1'b0;
        bi.pc_s1 = '0;
        bi.branch_s1 = 1'b0;
        bi.jump_s1 = 1'b0;
        bi.funct3_s1 = 3'b000;
        bi.rs1_data_s1 = '0;
        bi.rs2_data_s1 = '0;
        bi.predicted_taken_s1 = 1'b0;
        test_reset();
        test_compare();
        test_training();
        test_back_to_back();
        test_alias();
        test_stall();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/rvx_core_branch_predictor.md
# rvx_core_branch_predictor

Parametrised branch unit for the RVX core that replaces the fixed 32-bit comparator with an XLEN-wide resolver plus a dynamic branch history table (BHT) of 2-bit saturating counters. It predicts taken/not-taken for the fetch-stage PC (s0). It resolves conditional branches and jumps in stage s1, flags mispredictions and trains the table. It also maintains saturating branch and misprediction statistics counters for the CSR block.

## Interface
- XLEN, 32: operand and PC width.
- BHT_DEPTH, 64: number of BHT entries; power of two, ≥ 2; IDX_W = log2(BHT_DEPTH).
- COUNTER_INIT, 2'b01: reset value of every BHT counter (weakly not-taken).
- PREDICT_ENABLE, 1: 1 = dynamic prediction; 0 = static not-taken, table never written.
- STAT_WIDTH, 32: width of the statistics counters.

- clock  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_s0  input  XLEN  fetch PC to predict.
- predict_taken_s0  output  1  prediction for pc_s0.
- valid_s1  input  1  s1 holds a live instruction (not flushed, not stalled).
- pc_s1  input  XLEN  PC of the s1 instruction.
- branch_s1  input  1  s1 instruction is a conditional branch.
- jump_s1  input  1  s1 instruction is JAL/JALR.
- funct3_s1  input  3  branch funct3.
- rs1_data_s1, rs2_data_s1  input  XLEN  branch operands.
- predicted_taken_s1  input  1  prediction carried down from s0 with this instruction.
- take_branch_s1  output  1  resolved control transfer.
- mispredict_s1  output  1  conditional-branch outcome differs from prediction.
- branch_count  output  STAT_WIDTH  number of resolved conditional branches.
- mispredict_count  output  STAT_WIDTH  number of mispredicted conditional branches.

## Operation
- Index: idx(pc) = pc[IDX_W+1:2]. Bits [1:0] are ignored, and higher bits alias.
- Prediction: predict_taken_s0 = PREDICT_ENABLE & BHT[idx(pc_s0)][1].
- Comparisons are XLEN-wide:
  - eq: rs1 == rs2.
  - ltu: unsigned rs1 < rs2.
  - lt: if the MSBs of rs1 and rs2 differ, lt = rs1 MSB; otherwise lt = ltu.
- Conditions by funct3:
  - BEQ = eq; BNE = !eq; BLT = lt; BGE = !lt; BLTU = ltu; BGEU = !ltu.
  - funct3 010 and 011 give condition 0.
- take_branch_s1 = jump_s1 | (branch_s1 & cond). This does not depend on valid_s1.
- If jump_s1 and branch_s1 are both 1, the jump wins: take_branch_s1 = 1, and the instruction is treated as a jump.
- mispredict_s1 = valid_s1 & branch_s1 & !jump_s1 & (cond != predicted_taken_s1). Jumps never mispredict here.
- Training happens when valid_s1 & branch_s1 & !jump_s1 & PREDICT_ENABLE. At the clock edge, BHT[idx(pc_s1)] updates:
  - if cond: +1, saturating at 2'b11;
  - else: −1, saturating at 2'b00.
- Statistics, for each valid_s1 & branch_s1 & !jump_s1:
  - branch_count increments by 1;
  - mispredict_count increments by 1 if mispredict_s1.
  - Both counters saturate at all-ones and never wrap.
  - Both count even when PREDICT_ENABLE = 0. In that mode predict_taken_s0 = 0, so every taken branch counts as a mispredict.
- Reset (asynchronous, any time, including mid-update):
  - all BHT entries = COUNTER_INIT;
  - branch_count = 0 and mispredict_count = 0;
  - predict_taken_s0 = COUNTER_INIT[1] & PREDICT_ENABLE;
  - take_branch_s1 and mispredict_s1 remain purely combinational from their inputs.
  - An update pending at the moment reset asserts is discarded.

## Timing
- predict_taken_s0, take_branch_s1, mispredict_s1: combinational, zero latency.
- A BHT update is visible to predict_taken_s0 from the cycle after the training edge.
- Same-cycle read/write of the same index: s0 sees the old counter value. There is no bypass.
- Statistics counters reflect an event one cycle after the resolve edge.
- Back-to-back training of the same index in consecutive cycles must apply every step (for example 00 → 01 → 10 in two cycles).
- valid_s1 = 0 (stall or flush) blocks all state changes. The combinational outputs still follow their inputs.

## Test plan
- Reset, then read pc_s0 = 0x0, 0x4, 0xFC → predict_taken_s0 = 0. Both counters = 0.
- Signed compare with XLEN = 32, rs1 = 0x8000_0000, rs2 = 0x0000_0001:
  - BLT → take = 1; BLTU → take = 0; BGE → take = 0; BGEU → take = 1.
  - funct3 = 010 → take = 0.
  - jump_s1 = 1 with any funct3 → take = 1, mispredict_s1 = 0.
- Training at pc_s1 = 0x40 (idx 16), taken BEQ with rs1 = rs2 = 5, predicted_taken_s1 = 0, three valid cycles:
  - mispredict_s1 = 1, 0, 0;
  - counter 01 → 10 → 11 → 11;
  - predict_taken_s0 for pc = 0x40 becomes 1 after the first edge;
  - branch_count = 3, mispredict_count = 1.
- Aliasing and bypass: train pc_s1 = 0x100 (idx 0, BHT_DEPTH = 64) taken while pc_s0 = 0x0 in the same cycle → predict_taken_s0 = 0 that cycle, 1 the next.
- valid_s1 = 0 with branch_s1 = 1 for 10 cycles → BHT and both counters unchanged. take_branch_s1 still tracks the operands.
- Saturation with STAT_WIDTH = 4: run 20 mispredicted branches → both counters hold at 15.
- Asserting reset mid-sequence clears the counters and BHT asynchronously, before the next clock edge.
